dcache_req_arbiter: RTL and testbench

- Shares one D$ request port between NR_PORTS requesters: store buffer commit path, AMO buffer and PTW/load-side clients.
- Round-robin arbitration; the winner is locked until the cache returns gnt.
- Port IDs of accepted requests are recorded in order, so in-order read responses (rvalid/rdata) route back to the issuing requester.
- Sits between the LSU store/AMO path and the cache controller.

---
 rtl/dcache_req_arbiter_pkg.sv | 12 +
 rtl/dcache_req_arbiter_id_fifo.sv | 54 +++++
 rtl/dcache_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_req_arbiter_pkg.sv
// Shared definitions for the D$ request arbiter: default cache geometry and FSM states.
package dcache_req_arbiter_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/dcache_req_arbiter_id_fifo.sv
// Small synchronous FIFO holding the port IDs of accepted reads, oldest at the head.
module id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one D$ request port; locks the winner until gnt and
// routes in-order read responses back to the issuing port.
module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned ADDR_W          = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_W           = DCACHE_TAG_WIDTH,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NR_PORTS-1:0]                 req_i,
  input  logic [NR_PORTS-1:0]                 we_i,
  input  logic [NR_PORTS-1:0][ADDR_W-1:0]     addr_i,
  input  logic [NR_PORTS-1:0][TAG_W-1:0]      tag_i,
  input  logic [NR_PORTS-1:0][DATA_W-1:0]     data_i,
  input  logic [NR_PORTS-1:0][DATA_W/8-1:0]   be_i,
  input  logic [NR_PORTS-1:0][1:0]            size_i,
  output logic [NR_PORTS-1:0]                 gnt_o,
  output logic [NR_PORTS-1:0]                 rvalid_o,
  output logic [DATA_W-1:0]                   rdata_o,
  output logic                                dc_req_o,
  output logic                                dc_we_o,
  output logic [ADDR_W-1:0]                   dc_addr_o,
  output logic [TAG_W-1:0]                    dc_tag_o,
  output logic [DATA_W-1:0]                   dc_data_o,
  output logic [DATA_W/8-1:0]                 dc_be_o,
  output logic [1:0]                          dc_size_o,
  input  logic                                dc_gnt_i,
  input  logic                                dc_rvalid_i,
  input  logic [DATA_W-1:0]                   dc_rdata_i,
  output logic                                idle_o
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [IDX_W-1:0]  arb_idx, sel, fifo_head;
  logic              arb_valid, accept;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NR_PORTS-1:0] eligible;
  int unsigned       cand;

  // Reads need a routing slot; writes never produce a response so they bypass a full FIFO.
  assign eligible = req_i & (we_i | {NR_PORTS{~fifo_full}});

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NR_PORTS) cand = cand - NR_PORTS;
      if (!arb_valid && eligible[IDX_W'(cand)]) begin
        arb_valid = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  assign sel      = (state_q == LOCKED) ? winner_q : arb_idx;
  assign dc_req_o = (state_q == LOCKED) ? req_i[winner_q] : arb_valid;
  assign fifo_pop = dc_rvalid_i && !fifo_empty;
  assign accept   = dc_req_o && dc_gnt_i && (we_i[sel] || !fifo_full || fifo_pop);
  assign fifo_push = accept && !we_i[sel];

  assign dc_we_o   = we_i[sel];
  assign dc_addr_o = addr_i[sel];
  assign dc_tag_o  = tag_i[sel];
  assign dc_data_o = data_i[sel];
  assign dc_be_o   = be_i[sel];
  assign dc_size_o = size_i[sel];

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    if (fifo_pop) rvalid_o[fifo_head] = 1'b1;
  end

  assign rdata_o = dc_rdata_i;
  assign idle_o  = (state_q == IDLE) && fifo_empty && !dc_req_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
    end
  end

  // An unaccepted IDLE request locks its port; a dropped request abandons the lock.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rr_ptr_d = (sel == IDX_W'(NR_PORTS - 1)) ? '0 : sel + 1'b1;
        end else if (dc_req_o) begin
          winner_d = sel;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          rr_ptr_d = (sel == IDX_W'(NR_PORTS - 1)) ? '0 : sel + 1'b1;
          state_d  = IDLE;
        end else if (!dc_req_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_locked_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> req_i[winner_q]);
  a_rvalid_has_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
    dc_rvalid_i |-> !fifo_empty);
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o) && (dc_gnt_i || gnt_o == '0));

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed self-checking bench for dcache_req_arbiter with hand-computed expectations.
module tb_dcache_req_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [2:0]        req_i, we_i;
  logic [2:0][11:0]  addr_i;
  logic [2:0][43:0]  tag_i;
  logic [2:0][63:0]  data_i;
  logic [2:0][7:0]   be_i;
  logic [2:0][1:0]   size_i;
  logic [2:0]        gnt_o, rvalid_o;
  logic [63:0]       rdata_o;
  logic              dc_req_o, dc_we_o;
  logic [11:0]       dc_addr_o;
  logic [43:0]       dc_tag_o;
  logic [63:0]       dc_data_o;
  logic [7:0]        dc_be_o;
  logic [1:0]        dc_size_o;
  logic              dc_gnt_i, dc_rvalid_i;
  logic [63:0]       dc_rdata_i;
  logic              idle_o;

  int check_count = 0;
  int error_count = 0;

  always #5 clk_i = ~clk_i;

  dcache_req_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .tag_i       (tag_i),
    .data_i      (data_i),
    .be_i        (be_i),
    .size_i      (size_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .dc_req_o    (dc_req_o),
    .dc_we_o     (dc_we_o),
    .dc_addr_o   (dc_addr_o),
    .dc_tag_o    (dc_tag_o),
    .dc_data_o   (dc_data_o),
    .dc_be_o     (dc_be_o),
    .dc_size_o   (dc_size_o),
    .dc_gnt_i    (dc_gnt_i),
    .dc_rvalid_i (dc_rvalid_i),
    .dc_rdata_i  (dc_rdata_i),
    .idle_o      (idle_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; checks follow 1ns later.
  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] we,
                               input logic gnt, input logic rvalid,
                               input logic [63:0] rdata, input logic flush);
    @(negedge clk_i);
    req_i       = req;
    we_i        = we;
    dc_gnt_i    = gnt;
    dc_rvalid_i = rvalid;
    dc_rdata_i  = rdata;
    flush_i     = flush;
    #1;
  endtask

  function automatic logic [2:0] port_oh(input int p);
    return 3'(1 << p);
  endfunction

  int seq1[4] = '{0, 1, 2, 0};
  int seq3[4] = '{1, 2, 0, 1};
  int drain4[4] = '{1, 0, 2, 0};

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_i = '0; we_i = '0;
    dc_gnt_i = 1'b0; dc_rvalid_i = 1'b0; dc_rdata_i = '0;
    for (int p = 0; p < 3; p++) begin
      addr_i[p] = 12'h100 + 12'(p);
      tag_i[p]  = 44'hA000 + 44'(p);
      data_i[p] = 64'hD0D0_0000_0000_0000 + 64'(p);
      be_i[p]   = 8'hFF;
      size_i[p] = 2'd3;
    end

    $display("[TB] reset state");
    #12;
    checkOutput("rst_gnt", gnt_o, 3'b000);
    checkOutput("rst_rvalid", rvalid_o, 3'b000);
    checkOutput("rst_dc_req", dc_req_o, 1'b0);
    checkOutput("rst_idle", idle_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] round robin with back-to-back responses");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b111, 3'b000, 1'b1, k > 0, 64'h5000 + 64'(k), 1'b0);
      checkOutput("rr_gnt", gnt_o, port_oh(seq1[k]));
      checkOutput("rr_addr", dc_addr_o, 12'h100 + 12'(seq1[k]));
      checkOutput("rr_tag", dc_tag_o, 44'hA000 + 44'(seq1[k]));
      if (k > 0) begin
        checkOutput("rr_rvalid", rvalid_o, port_oh(seq1[k-1]));
        checkOutput("rr_rdata", rdata_o, 64'h5000 + 64'(k));
      end
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'h5004, 1'b0);
    checkOutput("rr_last_rvalid", rvalid_o, 3'b001);
    checkOutput("rr_last_rdata", rdata_o, 64'h5004);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("rr_idle", idle_o, 1'b1);

    $display("[TB] lock held while gnt is low");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b011, 3'b000, k == 3, 1'b0, 64'h0, 1'b0);
      checkOutput("lock_addr", dc_addr_o, 12'h101);
      checkOutput("lock_gnt", gnt_o, (k == 3) ? 3'b010 : 3'b000);
    end
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("lock_next_gnt", gnt_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'h6001, 1'b0);
    checkOutput("lock_rvalid1", rvalid_o, 3'b010);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'h6002, 1'b0);
    checkOutput("lock_rvalid2", rvalid_o, 3'b001);

    $display("[TB] full FIFO blocks reads but not writes");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
      checkOutput("full_fill_gnt", gnt_o, port_oh(seq3[k]));
    end
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("full_dc_req", dc_req_o, 1'b0);
    checkOutput("full_gnt", gnt_o, 3'b000);
    checkOutput("full_idle", idle_o, 1'b0);
    applyStimulus(3'b111, 3'b100, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("full_wr_gnt", gnt_o, 3'b100);
    checkOutput("full_wr_we", dc_we_o, 1'b1);
    checkOutput("full_wr_data", dc_data_o, 64'hD0D0_0000_0000_0002);
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b1, 64'h7000, 1'b0);
    checkOutput("full_pop_dc_req", dc_req_o, 1'b0);
    checkOutput("full_pop_rvalid", rvalid_o, 3'b010);
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("full_after_pop_gnt", gnt_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'h7001, 1'b0);
    checkOutput("full_drain_rvalid", rvalid_o, 3'b100);

    $display("[TB] simultaneous push and pop at count 3");
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b1, 64'hAA, 1'b0);
    checkOutput("pp_gnt", gnt_o, 3'b100);
    checkOutput("pp_rvalid", rvalid_o, 3'b001);
    checkOutput("pp_rdata", rdata_o, 64'hAA);
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("pp_fourth_gnt", gnt_o, 3'b001);
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("pp_full_dc_req", dc_req_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'hC0 + 64'(k), 1'b0);
      checkOutput("pp_drain_rvalid", rvalid_o, port_oh(drain4[k]));
    end
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("pp_idle", idle_o, 1'b1);

    $display("[TB] flush while locked");
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("fl_gnt1", gnt_o, 3'b010);
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("fl_gnt2", gnt_o, 3'b001);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("fl_lock_addr", dc_addr_o, 12'h102);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("fl_held_addr", dc_addr_o, 12'h102);
    applyStimulus(3'b001, 3'b001, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("fl_post_gnt", gnt_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'hB1, 1'b0);
    checkOutput("fl_rvalid1", rvalid_o, 3'b010);
    checkOutput("fl_rdata1", rdata_o, 64'hB1);
    checkOutput("fl_busy", idle_o, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'hB2, 1'b0);
    checkOutput("fl_rvalid2", rvalid_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("fl_idle", idle_o, 1'b1);

    $display("[TB] reset while locked with two outstanding");
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_gnt1", gnt_o, 3'b010);
    applyStimulus(3'b011, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_gnt2", gnt_o, 3'b001);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_locked_req", dc_req_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b0; req_i = 3'b000; dc_gnt_i = 1'b1; dc_rvalid_i = 1'b1;
    #1;
    checkOutput("mr_gnt", gnt_o, 3'b000);
    checkOutput("mr_rvalid", rvalid_o, 3'b000);
    checkOutput("mr_dc_req", dc_req_o, 1'b0);
    checkOutput("mr_idle", idle_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1; dc_rvalid_i = 1'b0; dc_gnt_i = 1'b0;
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_rr_restart", gnt_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_one_outstanding", idle_o, 1'b0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 64'hE0, 1'b0);
    checkOutput("mr_rvalid_after", rvalid_o, 3'b001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("mr_final_idle", idle_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
